// File: rtl/psum_depacketizer.sv
// psum_depacketizer: filters NoC psum packets and streams their slots, one extended psum per beat
module psum_depacketizer #(
    parameter int DWIDTH = 8,
    parameter int NPSUM = 4,
    parameter int OWIDTH = 16,
    parameter int SIGNED = 1,
    parameter int ADDRW = 4,
    parameter int TYPEW = 3,
    parameter logic [ADDRW-1:0] MY_ADDR = 4'h3,
    parameter logic [TYPEW-1:0] PSUM_TYPE = 3'd2,
    localparam int CNTW = $clog2(NPSUM + 1),
    localparam int PWIDTH = 2 * ADDRW + TYPEW + CNTW + NPSUM * DWIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PWIDTH-1:0] in_packet,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OWIDTH-1:0] out_psum,
    output logic [CNTW-1:0]   out_idx,
    output logic [ADDRW-1:0]  out_src,
    output logic              out_last,
    output logic [15:0]       drop_count
);
    typedef enum logic {IDLE, STREAM} state_t;
    state_t state, state_n;
    logic [CNTW-1:0] idx, cnt, pcnt;
    logic [ADDRW-1:0] src, psrc, pdest;
    logic [TYPEW-1:0] ptype;
    logic [NPSUM*DWIDTH-1:0] slots;
    logic [DWIDTH-1:0] slot;
    logic [OWIDTH-1:0] ext;
    logic accept, good, fire, last;

    assign pdest = in_packet[PWIDTH-1 -: ADDRW];
    assign psrc = in_packet[PWIDTH-1-ADDRW -: ADDRW];
    assign ptype = in_packet[NPSUM*DWIDTH+CNTW +: TYPEW];
    assign pcnt = in_packet[NPSUM*DWIDTH +: CNTW];
    assign good = pdest == MY_ADDR && ptype == PSUM_TYPE && pcnt != '0 && pcnt <= CNTW'(NPSUM);
    // The current slot always sits at the bottom of the shifted slot register
    assign slot = slots[DWIDTH-1:0];

    if (OWIDTH == DWIDTH) begin : g_pass
        assign ext = slot;
    end else begin : g_ext
        assign ext = {{(OWIDTH-DWIDTH){SIGNED != 0 && slot[DWIDTH-1]}}, slot};
    end

    always_comb begin
        state_n = state;
        in_ready = state == IDLE && !reset;
        out_valid = state == STREAM;
        accept = in_valid && in_ready;
        fire = out_valid && out_ready;
        last = out_valid && idx == cnt - CNTW'(1);
        if (accept && good) state_n = STREAM;
        if (fire && last) state_n = IDLE;
    end

    assign out_psum = out_valid ? ext : '0;
    assign out_idx = out_valid ? idx : '0;
    assign out_src = out_valid ? src : '0;
    assign out_last = last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx <= '0;
            cnt <= '0;
            src <= '0;
            slots <= '0;
            drop_count <= '0;
        end else begin
            state <= state_n;
            if (accept && good) begin
                idx <= '0;
                cnt <= pcnt;
                src <= psrc;
                slots <= in_packet[NPSUM*DWIDTH-1:0];
            end else if (fire && !last) begin
                idx <= idx + CNTW'(1);
                slots <= slots >> DWIDTH;
            end
            if (accept && !good && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_psum_depacketizer.sv
// tb_psum_depacketizer: directed checks of filtering, streaming, extension, stall, reset and saturation
module tb_psum_depacketizer;
    logic clk = 0, reset = 1, in_valid = 0, out_ready = 1;
    logic [45:0] in_packet = '0;
    logic in_ready, out_valid, out_last, u_in_ready, u_out_valid, u_out_last;
    logic [15:0] out_psum, drop_count, u_out_psum, u_drop_count;
    logic [2:0] out_idx, u_out_idx;
    logic [3:0] out_src, u_out_src;
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    psum_depacketizer #(.SIGNED(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_packet(in_packet),
        .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum), .out_idx(out_idx),
        .out_src(out_src), .out_last(out_last), .drop_count(drop_count)
    );

    psum_depacketizer #(.SIGNED(0)) dut_u (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(u_in_ready), .in_packet(in_packet),
        .out_valid(u_out_valid), .out_ready(out_ready), .out_psum(u_out_psum), .out_idx(u_out_idx),
        .out_src(u_out_src), .out_last(u_out_last), .drop_count(u_drop_count)
    );

    function automatic logic [45:0] mk(input logic [3:0] d, s, input logic [2:0] t, c,
                                       input logic [7:0] s3, s2, s1, s0);
        return {d, s, t, c, s3, s2, s1, s0};
    endfunction

    task automatic send(input logic [45:0] p);
        in_packet = p;
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic beat(input string nm, input logic [15:0] ep, input logic [2:0] ei,
                        input logic [3:0] es, input logic el);
        vectors++;
        if (out_valid !== 1'b1 || out_psum !== ep || out_idx !== ei || out_src !== es || out_last !== el) begin
            miscompares++;
            $display("FAIL %s: got v=%b psum=%h idx=%0d src=%0d last=%b, want v=1 psum=%h idx=%0d src=%0d last=%b",
                     nm, out_valid, out_psum, out_idx, out_src, out_last, ep, ei, es, el);
        end
    endtask

    task automatic test_reset;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_psum !== 16'h0 || out_idx !== 3'd0 ||
            out_src !== 4'd0 || out_last !== 1'b0 || drop_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_state: rdy=%b v=%b psum=%h idx=%0d src=%0d last=%b drops=%0d, want all 0",
                     in_ready, out_valid, out_psum, out_idx, out_src, out_last, drop_count);
        end
        reset = 0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic_stream;
        logic [15:0] ep [3] = '{16'h007F, 16'hFF80, 16'h0001};
        out_ready = 1;
        send(mk(4'd3, 4'd5, 3'd2, 3'd3, 8'h00, 8'h01, 8'h80, 8'h7F));
        for (int i = 0; i < 3; i++) begin
            beat("basic_beat", ep[i], 3'(i), 4'd5, i == 2);
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL basic_busy_ready: got %b want 0 at beat %0d", in_ready, i);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_after_last: v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_zero_extend;
        logic [15:0] ep [3] = '{16'h007F, 16'h0080, 16'h0001};
        send(mk(4'd3, 4'd5, 3'd2, 3'd3, 8'h00, 8'h01, 8'h80, 8'h7F));
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (u_out_valid !== 1'b1 || u_out_psum !== ep[i] || u_out_idx !== 3'(i) || u_out_last !== (i == 2)) begin
                miscompares++;
                $display("FAIL zext_beat: got v=%b psum=%h idx=%0d last=%b, want v=1 psum=%h idx=%0d last=%b",
                         u_out_valid, u_out_psum, u_out_idx, u_out_last, ep[i], i, i == 2);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (u_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL zext_end: v=%b want 0", u_out_valid);
        end
    endtask

    task automatic test_backpressure;
        send(mk(4'd3, 4'd5, 3'd2, 3'd3, 8'h00, 8'h01, 8'h80, 8'h7F));
        beat("bp_beat0", 16'h007F, 3'd0, 4'd5, 1'b0);
        @(posedge clk); #1;
        out_ready = 0;
        repeat (4) begin
            beat("bp_stall", 16'hFF80, 3'd1, 4'd5, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1;
        beat("bp_resume1", 16'hFF80, 3'd1, 4'd5, 1'b0);
        @(posedge clk); #1;
        beat("bp_resume2", 16'h0001, 3'd2, 4'd5, 1'b1);
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_end: v=%b want 0", out_valid);
        end
    endtask

    task automatic test_filtering;
        logic [45:0] bad [4];
        bad[0] = mk(4'd4, 4'd5, 3'd2, 3'd3, 8'h1, 8'h2, 8'h3, 8'h4);
        bad[1] = mk(4'd3, 4'd5, 3'd1, 3'd3, 8'h1, 8'h2, 8'h3, 8'h4);
        bad[2] = mk(4'd3, 4'd5, 3'd2, 3'd0, 8'h1, 8'h2, 8'h3, 8'h4);
        bad[3] = mk(4'd3, 4'd5, 3'd2, 3'd5, 8'h1, 8'h2, 8'h3, 8'h4);
        in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_packet = bad[i];
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL filter_drop%0d: v=%b rdy=%b want v=0 rdy=1", i, out_valid, in_ready);
            end
        end
        in_valid = 0;
        vectors++;
        if (drop_count !== 16'd4) begin
            miscompares++;
            $display("FAIL filter_count: got %0d want 4", drop_count);
        end
    endtask

    task automatic test_reset_mid;
        send(mk(4'd3, 4'd9, 3'd2, 3'd4, 8'h44, 8'h33, 8'h22, 8'h11));
        @(posedge clk); #1;
        beat("rst_pre", 16'h0022, 3'd1, 4'd9, 1'b0);
        #2 reset = 1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || drop_count !== 16'd0 || out_psum !== 16'h0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid: v=%b drops=%0d psum=%h rdy=%b want 0/0/0/0", out_valid, drop_count, out_psum, in_ready);
        end
        @(posedge clk); #1;
        reset = 0;
        send(mk(4'd3, 4'd6, 3'd2, 3'd2, 8'h00, 8'h00, 8'h22, 8'h11));
        beat("rst_next0", 16'h0011, 3'd0, 4'd6, 1'b0);
        @(posedge clk); #1;
        beat("rst_next1", 16'h0022, 3'd1, 4'd6, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic test_full_saturation;
        send(mk(4'd3, 4'd7, 3'd2, 3'd4, 8'hFF, 8'hFF, 8'hFF, 8'hFF));
        for (int i = 0; i < 4; i++) begin
            beat("full_beat", 16'hFFFF, 3'(i), 4'd7, i == 3);
            @(posedge clk); #1;
        end
        in_packet = mk(4'd4, 4'd7, 3'd2, 3'd1, 8'h0, 8'h0, 8'h0, 8'h1);
        in_valid = 1;
        repeat (65535) @(posedge clk);
        #1;
        vectors++;
        if (drop_count !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL sat_preload: got %h want ffff", drop_count);
        end
        @(posedge clk); #1;
        in_valid = 0;
        vectors++;
        if (drop_count !== 16'hFFFF || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_hold: drops=%h v=%b want ffff/0", drop_count, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_zero_extend();
        test_backpressure();
        test_filtering();
        test_reset_mid();
        test_full_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
